// File: rtl/par_serial_rx.sv
// Serial receiver for parity-protected words. Each frame is a start bit,
// DATA_W data bits sent LSB first, one parity bit and a stop bit. The word
// is delivered together with a parity error flag and a framing error flag.
//
// state  | meaning
// IDLE   | waiting for a falling edge on the synchronised line
// START  | timing to mid start bit to confirm it (reject glitches)
// DATA   | sampling data bits at mid-bit, LSB first
// PARITY | sampling the parity bit
// STOP   | sampling the stop bit, then delivering the word
module par_serial_rx #(
    parameter int DATA_W       = 7,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_i,
    input  logic              cbit,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              par_err_o,
    output logic              frame_err_o,
    output logic              busy_o
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic               par_q, par_d;
    logic               cbit_q, cbit_d;
    logic               load;
    logic               rx_meta, rx_s, rx_prev;

    // Two-flop synchroniser plus previous sample for falling-edge detection;
    // all reset to the idle-high line level so reset never looks like a start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    // Next-state, bit timing and sampling decisions.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        cbit_d  = cbit_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s && rx_prev) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        cbit_d  = cbit;
                        idx_d   = '0;
                        state_d = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    if (idx_q == IDX_LAST) begin
                        state_d = PARITY;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            PARITY: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    par_d   = rx_s;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    load    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State and frame-assembly registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            cbit_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            cbit_q  <= cbit_d;
        end
    end

    // Delivered word and flags; held until the next frame completes. The
    // stop bit sampled here is the live synchronised line at mid-stop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_o      <= '0;
            valid_o     <= 1'b0;
            par_err_o   <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            valid_o <= load;
            if (load) begin
                data_o      <= shift_q;
                par_err_o   <= par_q ^ (^shift_q) ^ cbit_q;
                frame_err_o <= ~rx_s;
            end
        end
    end

    assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_par_serial_rx.sv
// Bench for par_serial_rx: directed frames from the receiver's usage notes
// plus back-to-back and randomized frames, checked against a queue-based
// reference of expected words.
module tb_par_serial_rx;

    localparam int DW  = 7;
    localparam int CPB = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx_i = 1'b1;
    logic          cbit = 1'b0;
    logic [DW-1:0] data_o;
    logic          valid_o;
    logic          par_err_o;
    logic          frame_err_o;
    logic          busy_o;

    typedef struct {
        logic [DW-1:0] data;
        logic          perr;
        logic          ferr;
    } exp_t;

    exp_t          exp_q[$];
    int            vectors = 0;
    int            miscompares = 0;
    int            pulses = 0;
    logic [DW-1:0] last_data = '0;
    logic          last_perr = 1'b0;
    logic          last_ferr = 1'b0;

    par_serial_rx #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_i        (rx_i),
        .cbit        (cbit),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .par_err_o   (par_err_o),
        .frame_err_o (frame_err_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Sends one frame at the exact bit rate; optionally toggles cbit every
    // 10 clks once the start bit has been confirmed.
    task automatic send_frame(input logic [DW-1:0] d, input logic pb, input logic sb,
                              input logic cb, input bit tog, input bit expect_it);
        logic [DW+2:0] bits;
        exp_t          e;
        logic          good_p;
        bits   = {sb, pb, d, 1'b0};
        good_p = 1'(($countones(d) + int'(cb)) % 2);
        if (expect_it) begin
            e.data = d;
            e.perr = (pb != good_p);
            e.ferr = ~sb;
            exp_q.push_back(e);
        end
        cbit = cb;
        for (int b = 0; b < DW + 3; b++) begin
            for (int c = 0; c < CPB; c++) begin
                rx_i = bits[b];
                if (tog && (b * CPB + c) >= 20 && ((b * CPB + c) % 10) == 0) cbit = ~cbit;
                wait_clks(1);
            end
        end
        check("frame_delivered_by_stop_end", exp_q.size(), 0);
    endtask

    // Reference compare: every cycle, a pulse must match the oldest expected
    // word, and outside pulses the outputs must hold the last delivered word.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_valid", valid_o, 0);
            check("rst_data", data_o, 0);
            check("rst_par_err", par_err_o, 0);
            check("rst_frame_err", frame_err_o, 0);
            check("rst_busy", busy_o, 0);
            last_data = '0;
            last_perr = 1'b0;
            last_ferr = 1'b0;
        end else if (valid_o) begin
            pulses++;
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL spurious_valid: got valid_o=1 data %0h, expected no pulse (t=%0t)", data_o, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("word_data", data_o, e.data);
                check("word_par_err", par_err_o, e.perr);
                check("word_frame_err", frame_err_o, e.ferr);
            end
            last_data = data_o;
            last_perr = par_err_o;
            last_ferr = frame_err_o;
        end else begin
            check("hold_data", data_o, last_data);
            check("hold_par_err", par_err_o, last_perr);
            check("hold_frame_err", frame_err_o, last_ferr);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no end of run, expected finish before 3ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        wait_clks(3);
        rst_n = 1'b1;
        wait_clks(20);

        // even parity, clean
        send_frame(7'h55, 1'b0, 1'b1, 1'b0, 0, 1);
        check("even_data", data_o, 32'h55);
        check("even_par_err", par_err_o, 0);
        check("even_frame_err", frame_err_o, 0);

        // even parity, wrong parity bit
        send_frame(7'h55, 1'b1, 1'b1, 1'b0, 0, 1);
        check("perr_data", data_o, 32'h55);
        check("perr_par_err", par_err_o, 1);
        check("perr_frame_err", frame_err_o, 0);

        // odd parity, both parity-bit values
        send_frame(7'h7F, 1'b0, 1'b1, 1'b1, 0, 1);
        check("odd_ok_par_err", par_err_o, 0);
        send_frame(7'h7F, 1'b1, 1'b1, 1'b1, 0, 1);
        check("odd_bad_par_err", par_err_o, 1);

        // cbit wiggling mid-frame must not matter
        send_frame(7'h01, 1'b0, 1'b1, 1'b1, 1, 1);
        check("capture_data", data_o, 32'h01);
        check("capture_par_err", par_err_o, 0);
        cbit = 1'b0;

        // start-bit glitch
        wait_clks(20);
        p0 = pulses;
        rx_i = 1'b0;
        wait_clks(4);
        rx_i = 1'b1;
        wait_clks(1);
        check("glitch_busy_seen", busy_o, 1);
        wait_clks(11);
        check("glitch_busy_cleared", busy_o, 0);
        wait_clks(200);
        check("glitch_no_pulse", pulses - p0, 0);

        // framing error followed by a break
        p0 = pulses;
        send_frame(7'h2A, 1'b1, 1'b0, 1'b0, 0, 1);
        wait_clks(20);
        check("break_no_retrigger", busy_o, 0);
        wait_clks(20);
        rx_i = 1'b1;
        wait_clks(32);
        check("break_one_pulse", pulses - p0, 1);
        check("break_data", data_o, 32'h2A);
        check("break_frame_err", frame_err_o, 1);
        check("break_par_err", par_err_o, 0);
        send_frame(7'h11, 1'b0, 1'b1, 1'b0, 0, 1);
        check("after_break_data", data_o, 32'h11);
        check("after_break_frame_err", frame_err_o, 0);
        wait_clks(16);

        // reset in the middle of the data bits
        p0 = pulses;
        rx_i = 1'b0;
        wait_clks(CPB);
        rx_i = 1'b1;
        wait_clks(2 * CPB);
        rx_i = 1'b0;
        wait_clks(1);
        rst_n = 1'b0;
        wait_clks(3);
        rx_i = 1'b1;
        rst_n = 1'b1;
        wait_clks(1);
        check("post_reset_busy", busy_o, 0);
        check("post_reset_data", data_o, 0);
        wait_clks(200);
        check("reset_no_pulse", pulses - p0, 0);
        send_frame(7'h33, 1'b0, 1'b1, 1'b0, 0, 1);
        check("after_reset_data", data_o, 32'h33);
        check("after_reset_par_err", par_err_o, 0);

        // back-to-back frames, every data value, even/odd alternating
        wait_clks(16);
        p0 = pulses;
        for (int i = 0; i < 128; i++) begin
            logic [DW-1:0] d;
            logic          cb;
            d  = DW'(i);
            cb = 1'(i % 2);
            send_frame(d, 1'(($countones(d) + int'(cb)) % 2), 1'b1, cb, 0, 1);
        end
        check("b2b_pulses", pulses - p0, 128);

        // randomized frames: data, mode, parity bit, stop bit, gaps
        for (int i = 0; i < 40; i++) begin
            logic [DW-1:0] d;
            logic          cb, pb, sb;
            bit            tog;
            int            gap;
            d   = DW'($urandom_range(0, 127));
            cb  = 1'($urandom_range(0, 1));
            pb  = 1'($urandom_range(0, 1));
            sb  = ($urandom_range(0, 7) != 0);
            tog = 1'($urandom_range(0, 1));
            send_frame(d, pb, sb, cb, tog, 1);
            gap = sb ? int'($urandom_range(0, 2)) : 1 + int'($urandom_range(0, 2));
            rx_i = 1'b1;
            wait_clks(gap * CPB);
        end

        wait_clks(200);
        check("final_queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
